// File: rtl/usb_tx_if.sv
// Signal bundle between a packet source/transmit FIFO and usb_tx_engine.
// The source drives the request and FIFO head; the engine drives the pop strobe, status and USB lines.
interface usb_tx_if #(
    parameter int OCC_W = 7
);
    logic [2:0]       tx_packet;
    logic [7:0]       tx_packet_data;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             get_tx_packet_data;
    logic             tx_transfer_active;
    logic             tx_error;
    logic             dplus_out;
    logic             dminus_out;

    // Handshake: tx_packet is a level request sampled only while the engine is idle. A legal
    // code is taken on the first idle clock edge; the source sees tx_transfer_active rise (or a
    // one-cycle tx_error on reject) and must drop the code before the engine is idle again, or
    // it is taken a second time. get_tx_packet_data pulses for one cycle after the engine has
    // captured tx_packet_data; the FIFO advances its head on that pulse.
    modport master (
        output tx_packet, tx_packet_data, buffer_occupancy,
        input  get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out
    );

    modport slave (
        input  tx_packet, tx_packet_data, buffer_occupancy,
        output get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out
    );
endinterface

// File: rtl/usb_tx_engine.sv
// USB full-speed packet transmitter: SYNC, PID, FIFO data and CRC16, with bit stuffing,
// NRZI line coding and SE0/J end-of-packet. The current FSM state is exported on fsm_state.
module usb_tx_engine #(
    parameter int CLKS_PER_BIT   = 8,
    parameter int MAX_DATA_BYTES = 64,
    parameter int OCC_W          = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic       clk,
    input  logic       n_rst,
    usb_tx_if.slave    bus,
    output logic [2:0] fsm_state
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] PID   = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] CRC   = 3'd4;
    localparam logic [2:0] EOP   = 3'd5;
    localparam logic [2:0] JIDLE = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);

    logic [2:0]       state, state_n;
    logic [2:0]       pkt, pkt_n;
    logic [OCC_W-1:0] n_bytes, n_bytes_n;
    logic [OCC_W-1:0] byte_cnt, byte_cnt_n;
    logic [7:0]       clk_cnt, clk_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [15:0]      crc, crc_n;
    logic [3:0]       crc_idx, crc_idx_n;
    logic [2:0]       ones, ones_n;
    logic             eop_cnt, eop_cnt_n;
    logic             line_j, line_j_n;
    logic             dplus, dplus_n;
    logic             dminus, dminus_n;
    logic             pop, pop_n;
    logic             err, err_n;

    logic       strobe, need_stuff, pkt_data;
    logic       req_legal, req_data, req_too_big;
    logic       send, send_bit, shift, load, start_crc, go_se0, go_j;
    logic [7:0] pid_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    // The accept edge drives the first SYNC bit, so every later strobe is a whole bit time after it.
    assign strobe      = (state != IDLE) && (clk_cnt == BIT_LAST);
    assign need_stuff  = (ones == 3'd6) && ((state == SYNC) || (state == PID) ||
                                            (state == DATA) || (state == CRC));
    assign pkt_data    = (pkt == 3'd1) || (pkt == 3'd2);
    assign req_legal   = (bus.tx_packet != 3'd0) && (bus.tx_packet <= 3'd5);
    assign req_data    = (bus.tx_packet == 3'd1) || (bus.tx_packet == 3'd2);
    assign req_too_big = bus.buffer_occupancy > OCC_W'(MAX_DATA_BYTES);

    always_comb begin
        case (pkt)
            3'd1:    pid_byte = 8'hC3;
            3'd2:    pid_byte = 8'h4B;
            3'd3:    pid_byte = 8'hD2;
            3'd4:    pid_byte = 8'h5A;
            default: pid_byte = 8'h1E;
        endcase
    end

    always_comb begin
        state_n    = state;
        pkt_n      = pkt;
        n_bytes_n  = n_bytes;
        byte_cnt_n = byte_cnt;
        clk_cnt_n  = clk_cnt;
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        crc_n      = crc;
        crc_idx_n  = crc_idx;
        ones_n     = ones;
        eop_cnt_n  = eop_cnt;
        line_j_n   = line_j;
        dplus_n    = dplus;
        dminus_n   = dminus;
        pop_n      = 1'b0;
        err_n      = 1'b0;
        send       = 1'b0;
        send_bit   = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        start_crc  = 1'b0;
        go_se0     = 1'b0;
        go_j       = 1'b0;

        if (state != IDLE) begin
            clk_cnt_n = strobe ? 8'd0 : clk_cnt + 8'd1;
        end

        if (state == IDLE) begin
            if (bus.tx_packet != 3'd0) begin
                if (!req_legal || (req_data && req_too_big)) begin
                    err_n = 1'b1;
                end else begin
                    state_n    = SYNC;
                    pkt_n      = bus.tx_packet;
                    n_bytes_n  = bus.buffer_occupancy;
                    byte_cnt_n = '0;
                    clk_cnt_n  = 8'd0;
                    crc_n      = 16'hFFFF;
                    shreg_n    = SYNC_BYTE;
                    bit_idx_n  = 3'd0;
                    send       = 1'b1;
                    send_bit   = SYNC_BYTE[0];
                end
            end
        end else if (strobe) begin
            if (need_stuff) begin
                // Stuffed zero: the shifter and CRC position hold for this bit time.
                send     = 1'b1;
                send_bit = 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (bit_idx != 3'd7) begin
                            shift = 1'b1;
                        end else begin
                            state_n   = PID;
                            shreg_n   = pid_byte;
                            bit_idx_n = 3'd0;
                            send      = 1'b1;
                            send_bit  = pid_byte[0];
                        end
                    end
                    PID: begin
                        if (bit_idx != 3'd7)        shift     = 1'b1;
                        else if (!pkt_data)         go_se0    = 1'b1;
                        else if (n_bytes != '0)     load      = 1'b1;
                        else                        start_crc = 1'b1;
                    end
                    DATA: begin
                        if (bit_idx != 3'd7)           shift     = 1'b1;
                        else if (byte_cnt != n_bytes)  load      = 1'b1;
                        else                           start_crc = 1'b1;
                    end
                    CRC: begin
                        if (crc_idx != 4'd15) begin
                            crc_n     = {crc[14:0], 1'b0};
                            crc_idx_n = crc_idx + 4'd1;
                            send      = 1'b1;
                            send_bit  = ~crc[14];
                        end else begin
                            go_se0 = 1'b1;
                        end
                    end
                    EOP: begin
                        if (!eop_cnt) eop_cnt_n = 1'b1;
                        else          go_j      = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        if (shift) begin
            shreg_n   = {1'b0, shreg[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            send      = 1'b1;
            send_bit  = shreg[1];
            if (state == DATA) crc_n = crc_step(crc, shreg[1]);
        end
        if (load) begin
            state_n    = DATA;
            shreg_n    = bus.tx_packet_data;
            bit_idx_n  = 3'd0;
            byte_cnt_n = byte_cnt + OCC_W'(1);
            pop_n      = 1'b1;
            send       = 1'b1;
            send_bit   = bus.tx_packet_data[0];
            crc_n      = crc_step(crc, bus.tx_packet_data[0]);
        end
        if (start_crc) begin
            state_n   = CRC;
            crc_idx_n = 4'd0;
            send      = 1'b1;
            send_bit  = ~crc[15];
        end
        if (go_se0) begin
            state_n   = EOP;
            eop_cnt_n = 1'b0;
            dplus_n   = 1'b0;
            dminus_n  = 1'b0;
        end
        if (go_j) begin
            state_n  = JIDLE;
            line_j_n = 1'b1;
            dplus_n  = 1'b1;
            dminus_n = 1'b0;
        end
        // NRZI: a zero toggles J/K, a one holds; the ones run restarts on any zero.
        if (send) begin
            line_j_n = send_bit ? line_j : ~line_j;
            dplus_n  = line_j_n;
            dminus_n = ~line_j_n;
            ones_n   = send_bit ? ones + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            pkt      <= 3'd0;
            n_bytes  <= '0;
            byte_cnt <= '0;
            clk_cnt  <= 8'd0;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            crc      <= 16'd0;
            crc_idx  <= 4'd0;
            ones     <= 3'd0;
            eop_cnt  <= 1'b0;
            line_j   <= 1'b1;
            dplus    <= 1'b1;
            dminus   <= 1'b0;
            pop      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            pkt      <= pkt_n;
            n_bytes  <= n_bytes_n;
            byte_cnt <= byte_cnt_n;
            clk_cnt  <= clk_cnt_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            crc      <= crc_n;
            crc_idx  <= crc_idx_n;
            ones     <= ones_n;
            eop_cnt  <= eop_cnt_n;
            line_j   <= line_j_n;
            dplus    <= dplus_n;
            dminus   <= dminus_n;
            pop      <= pop_n;
            err      <= err_n;
        end
    end

    assign bus.dplus_out          = dplus;
    assign bus.dminus_out         = dminus;
    assign bus.get_tx_packet_data = pop;
    assign bus.tx_error           = err;
    assign bus.tx_transfer_active = (state != IDLE);
    assign fsm_state              = state;
endmodule

// File: tb/tb_usb_tx_engine.sv
// Directed and randomized checks of usb_tx_engine against a bit-stream reference model
// built from the packet contents (SYNC/PID/data/CRC, stuffing, NRZI, EOP).
module tb_usb_tx_engine;
    localparam int CPB   = 8;
    localparam int MAXB  = 64;
    localparam int OCC_W = 7;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] fsm_state;
    int         total = 0;
    int         bad = 0;
    int         pop_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] pkt_bytes[$];
    logic [1:0] exp_q[$];

    usb_tx_if #(.OCC_W(OCC_W)) bus ();

    usb_tx_engine #(
        .CLKS_PER_BIT  (CPB),
        .MAX_DATA_BYTES(MAXB),
        .OCC_W         (OCC_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .fsm_state(fsm_state)
    );

    // Clock; reset is sequenced from the main initial block.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        bus.buffer_occupancy = OCC_W'(fifo_q.size());
    endtask

    // One clock; the FIFO model advances its head whenever the engine pops.
    task automatic tick();
        @(negedge clk);
        if (bus.get_tx_packet_data === 1'b1) begin
            pop_cnt++;
            if (fifo_q.size() > 0) fifo_q.delete(0);
            drive_fifo();
        end
    endtask

    task automatic build_expected(input logic [2:0] code);
        logic       raw[$];
        logic       st[$];
        logic [7:0] pid;
        logic [7:0] b;
        logic [15:0] c;
        logic       lvl;
        int         ones;
        exp_q.delete();
        case (code)
            3'd1:    pid = 8'hC3;
            3'd2:    pid = 8'h4B;
            3'd3:    pid = 8'hD2;
            3'd4:    pid = 8'h5A;
            default: pid = 8'h1E;
        endcase
        b = 8'h80;
        for (int i = 0; i < 8; i++) raw.push_back(b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
        if (code == 3'd1 || code == 3'd2) begin
            c = 16'hFFFF;
            foreach (pkt_bytes[j]) begin
                b = pkt_bytes[j];
                for (int i = 0; i < 8; i++) begin
                    raw.push_back(b[i]);
                    if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
                    else              c = {c[14:0], 1'b0};
                end
            end
            for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
        end
        ones = 0;
        foreach (raw[i]) begin
            st.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (st[i]) begin
            if (!st[i]) lvl = ~lvl;
            exp_q.push_back(lvl ? SYM_J : SYM_K);
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // Request one packet using the current FIFO contents and check it bit time by bit time.
    task automatic run_packet(input logic [2:0] code, input bit rel, input int inject_at,
                              input logic [2:0] inject_code);
        int          nsym, c, act, errs, k, budget, exp_pops, act2;
        logic [15:0] sync_seen;
        bit          done;
        if (code == 3'd1 || code == 3'd2) pkt_bytes = fifo_q;
        else                              pkt_bytes.delete();
        exp_pops = pkt_bytes.size();
        build_expected(code);
        nsym   = exp_q.size();
        budget = (nsym + 4) * CPB;
        drive_fifo();
        @(negedge clk);
        if (rel) n_rst = 1'b1;
        bus.tx_packet = code;
        pop_cnt = 0; act = 0; errs = 0; k = 0; c = 0; done = 1'b0; sync_seen = 16'd0;
        tick();
        bus.tx_packet = 3'd0;
        while (!done && c < budget) begin
            if (c == inject_at)     bus.tx_packet = inject_code;
            if (c == inject_at + 1) bus.tx_packet = 3'd0;
            if (bus.tx_error === 1'b1) errs++;
            if (bus.tx_transfer_active === 1'b1) begin
                act++;
                if ((c % CPB) == CPB / 2 && k < nsym) begin
                    if (k < 8) sync_seen = {sync_seen[13:0], bus.dplus_out, bus.dminus_out};
                    check($sformatf("line_bit%0d", k), {30'd0, bus.dplus_out, bus.dminus_out},
                          {30'd0, exp_q.pop_front()});
                    k++;
                end
                tick();
                c++;
            end else begin
                done = 1'b1;
            end
        end
        check("timeout", {31'd0, done}, 32'd1);
        check("active_len", act, nsym * CPB);
        check("bits_seen", k, nsym);
        check("pops", pop_cnt, exp_pops);
        check("err_in_pkt", errs, 0);
        check("idle_line", {30'd0, bus.dplus_out, bus.dminus_out}, {30'd0, SYM_J});
        check("idle_state", {29'd0, fsm_state}, 32'd0);
        if (code == 3'd3) check("ack_sync", {16'd0, sync_seen}, 32'h6665);
        if (inject_at >= 0) begin
            act2 = 0;
            for (int i = 0; i < 4 * CPB; i++) begin
                if (bus.tx_transfer_active !== 1'b0) act2++;
                tick();
            end
            check("late_req_ignored", act2, 0);
        end
    endtask

    task automatic err_test(input string tag, input logic [2:0] code, input int n);
        int errs, act, nonj;
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
        drive_fifo();
        @(negedge clk);
        bus.tx_packet = code;
        pop_cnt = 0;
        tick();
        bus.tx_packet = 3'd0;
        check({tag, "_pulse"}, {31'd0, bus.tx_error}, 32'd1);
        errs = 0; act = 0; nonj = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (bus.tx_error === 1'b1) errs++;
            if (bus.tx_transfer_active !== 1'b0) act++;
            if ({bus.dplus_out, bus.dminus_out} !== SYM_J) nonj++;
            tick();
        end
        check({tag, "_err_cycles"}, errs, 1);
        check({tag, "_active"}, act, 0);
        check({tag, "_line_not_j"}, nonj, 0);
        check({tag, "_pops"}, pop_cnt, 0);
        fifo_q.delete();
        drive_fifo();
    endtask

    initial begin
        logic [2:0] code;
        int         n;
        n_rst = 1'b0;
        bus.tx_packet = 3'd0;
        fifo_q.delete();
        drive_fifo();
        repeat (3) @(negedge clk);
        check("rst_dplus", {31'd0, bus.dplus_out}, 32'd1);
        check("rst_dminus", {31'd0, bus.dminus_out}, 32'd0);
        check("rst_pop", {31'd0, bus.get_tx_packet_data}, 32'd0);
        check("rst_active", {31'd0, bus.tx_transfer_active}, 32'd0);
        check("rst_err", {31'd0, bus.tx_error}, 32'd0);
        check("rst_state", {29'd0, fsm_state}, 32'd0);

        // ACK requested in the same cycle reset is released.
        run_packet(3'd3, 1'b1, -1, 3'd0);

        fifo_q = '{8'h00, 8'h01, 8'hFF};
        run_packet(3'd1, 1'b0, -1, 3'd0);

        fifo_q.delete();
        run_packet(3'd2, 1'b0, -1, 3'd0);
        run_packet(3'd4, 1'b0, -1, 3'd0);
        run_packet(3'd5, 1'b0, -1, 3'd0);

        err_test("code6", 3'd6, 0);
        err_test("code7", 3'd7, 0);
        err_test("data0_n65", 3'd1, 65);
        err_test("data1_n65", 3'd2, 65);

        fifo_q.delete();
        for (int i = 0; i < MAXB; i++) fifo_q.push_back(8'($urandom));
        run_packet(3'd2, 1'b0, -1, 3'd0);

        // Reset in the middle of the data field, then a clean ACK.
        fifo_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom));
        drive_fifo();
        @(negedge clk);
        bus.tx_packet = 3'd1;
        pop_cnt = 0;
        tick();
        bus.tx_packet = 3'd0;
        repeat (20 * CPB) tick();
        check("mid_pops", pop_cnt, 1);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_dplus", {31'd0, bus.dplus_out}, 32'd1);
        check("mid_rst_dminus", {31'd0, bus.dminus_out}, 32'd0);
        check("mid_rst_pop", {31'd0, bus.get_tx_packet_data}, 32'd0);
        check("mid_rst_active", {31'd0, bus.tx_transfer_active}, 32'd0);
        check("mid_rst_err", {31'd0, bus.tx_error}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        fifo_q.delete();
        run_packet(3'd3, 1'b0, -1, 3'd0);

        // A NAK request pulsed while the ACK is in EOP must be dropped.
        run_packet(3'd3, 1'b0, 16 * CPB + 2, 3'd4);

        for (int r = 0; r < 10; r++) begin
            code = 3'($urandom_range(1, 5));
            fifo_q.delete();
            if (code <= 3'd2) begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++)
                    fifo_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet(code, 1'b0, -1, 3'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
